lab2_qs_onchip_memory_burst: RTL and testbench
==============================================

# lab2_qs_onchip_memory_burst

Parametrised Avalon-MM on-chip RAM slave with burst capability, the next-generation replacement for the fixed 32-bit single-port Qsys on-chip memory. It has configurable data width, depth and read latency, linear read/write bursts with `readdatavalid`, `waitrequest` flow control, and defined out-of-range behaviour. It sits on the Nios II data/instruction interconnect as a pipelined burst-capable slave.

## Interface
- `DATA_WIDTH`, 32: word width, a multiple of 8.
- `ADDR_WIDTH`, 14: word address width.
- `DEPTH`, 10000: number of implemented words, at most 2^ADDR_WIDTH.
- `BURST_WIDTH`, 4: `burstcount` width; the maximum burst is 2^(BURST_WIDTH-1).
- `READ_LATENCY`, 1: 1 means unregistered RAM output; 2 means an extra output register.
- `INIT_FILE`, "": hex init file; empty means contents are undefined at configuration.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high; does not clear RAM contents.
- `address` in ADDR_WIDTH: word address of the first beat.
- `byteenable` in DATA_WIDTH/8: per-byte write enables, sampled per write beat.
- `chipselect` in 1: slave select.
- `read` in 1: read command.
- `write` in 1: write command or write beat.
- `writedata` in DATA_WIDTH: write data.
- `burstcount` in BURST_WIDTH: beats in the burst; 0 is treated as 1.
- `clken` in 1: global clock enable; low freezes the block.
- `waitrequest` out 1: command or beat not accepted this cycle.
- `readdata` out DATA_WIDTH: read data.
- `readdatavalid` out 1: `readdata` holds a valid beat.

## Operation
- State machine with three states: IDLE, RD_BURST, WR_BURST.
  - IDLE: a command is accepted when `chipselect & (read|write) & clken`.
  - `write` has priority if `read` and `write` are asserted together; the read is dropped.
- Read command with N beats:
  - Beat 0 is issued at the acceptance edge.
  - If N>1, go to RD_BURST. An internal address counter increments once per cycle and issues beats 1..N-1, then returns to IDLE.
  - `read`/`write` are ignored while in RD_BURST.
- Write command with N beats:
  - Beat 0 is written at the acceptance edge.
  - If N>1, go to WR_BURST. Each cycle with `chipselect & write & clken` writes one beat at the counter address and advances the counter.
  - Cycles with `write` low are gaps; the counter holds.
  - After beat N-1, return to IDLE. `read` is ignored in WR_BURST.
- Byte enables: only bytes with `byteenable[i]`=1 are modified.
- Address rules:
  - The counter is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
  - Beats with address ≥ DEPTH: writes are dropped; reads return all zeros with `readdatavalid` still asserted.
- Read-during-write to the same address returns the old data.
- `clken` low:
  - State, counters, the read pipeline and outputs hold.
  - No RAM access occurs.
  - `waitrequest` is forced high.
- `reset`:
  - State goes to IDLE, counters to 0, the read pipeline is flushed.
  - `readdata`=0, `readdatavalid`=0.
  - `waitrequest` follows its combinational rule (0 in IDLE with `clken`=1).
  - Reset mid-burst abandons the burst: no further beats are written or returned.

## Timing
- `waitrequest` = (state==RD_BURST) | ~`clken`. It is combinational from registered state only, with no path from `read`/`write`.
- Read beat i of a burst accepted at edge T: `readdata` and `readdatavalid`=1 are presented after edge T+READ_LATENCY+i.
  - Beats are back-to-back with no bubbles, except cycles frozen by `clken`.
- Next command acceptance:
  - After an N-beat read: earliest at edge T+N.
  - After a write burst: the edge following the last beat.
- `readdatavalid` is 0 on every cycle not carrying a beat.
- A single-beat read has the same latency as a burst beat 0.
- Write data is visible to a read issued on the edge after the write edge.

## Test plan
- Reset, then single-beat write 0xDEADBEEF to addr 5 with byteenable 0xF, then read addr 5 with READ_LATENCY=1 -> `readdatavalid` one cycle after acceptance with 0xDEADBEEF. Repeat with READ_LATENCY=2 -> valid two cycles after acceptance.
- Write burst of 4 to addr 0x10 with data 1,2,3,4 and a 2-cycle `write` gap after beat 1, then read burst of 4 from 0x10 -> `waitrequest` high for 3 cycles and four consecutive valid beats 1,2,3,4.
- Write 0xFFFFFFFF to addr 7, then write 0x00000000 with byteenable 0x5 -> read returns 0xFF00FF00.
- Read burst of 4 starting at DEPTH-2 -> beats are mem[DEPTH-2], mem[DEPTH-1], 0, 0. Write burst at the same start -> only the two in-range words change.
- Drop `clken` for 3 cycles mid read burst -> `waitrequest`=1, outputs hold, beat sequence resumes intact. Separately, assert `reset` after beat 1 of an 8-beat read -> `readdatavalid`=0 from the next cycle, state IDLE, a new command is accepted immediately.
- Simultaneous `read` & `write` in IDLE to addr 3 with data 0x55 -> write performed, no `readdatavalid`; a following read returns 0x55.

Source files
------------

// File: rtl/lab2_qs_onchip_memory_burst.sv
// Avalon-MM on-chip RAM slave with linear read/write bursts, byte enables,
// clock enable, configurable read latency and zero-fill for out-of-range reads.
module lab2_qs_onchip_memory_burst #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 14,
    parameter int    DEPTH        = 10000,
    parameter int    BURST_WIDTH  = 4,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic [BURST_WIDTH-1:0]    burstcount,
    input  logic                      clken,
    output logic                      waitrequest,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic [1:0]                dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    // Valid/ready: a command or write beat is taken on a rising edge where the
    // master holds it and waitrequest is low; waitrequest never depends on read/write.
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cnt_addr;
    logic [BURST_WIDTH-1:0] beats_left;
    logic                   iss_v;
    logic [ADDR_WIDTH-1:0]  iss_addr;
    logic                   ram_v;
    logic [DATA_WIDTH-1:0]  ram_q;

    logic                   cmd_accept;
    logic [BURST_WIDTH-1:0] n_beats;
    logic                   rd_issue;
    logic                   wr_beat;
    logic [ADDR_WIDTH-1:0]  beat_addr;
    logic                   beat_in_range;
    logic                   iss_in_range;
    logic [IDX_W-1:0]       beat_idx;
    logic [IDX_W-1:0]       iss_idx;

    assign waitrequest = (state == RD_BURST) | ~clken;
    assign dbg_state   = state;
    assign cmd_accept  = (state == IDLE) & chipselect & (read | write) & clken;
    assign n_beats     = (burstcount == '0) ? BURST_WIDTH'(1) : burstcount;

    // Decide which beat (if any) touches the RAM on the coming edge.
    always_comb begin
        rd_issue  = 1'b0;
        wr_beat   = 1'b0;
        beat_addr = cnt_addr;
        if (clken) begin
            case (state)
                IDLE: begin
                    if (chipselect && write) begin
                        wr_beat   = 1'b1;
                        beat_addr = address;
                    end else if (chipselect && read) begin
                        rd_issue  = 1'b1;
                        beat_addr = address;
                    end
                end
                RD_BURST: rd_issue = 1'b1;
                WR_BURST: wr_beat  = chipselect & write;
                default: ;
            endcase
        end
    end

    assign beat_in_range = {1'b0, beat_addr} < DEPTH_L;
    assign iss_in_range  = {1'b0, iss_addr} < DEPTH_L;
    assign beat_idx      = beat_addr[IDX_W-1:0];
    assign iss_idx       = iss_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (wr_beat && beat_in_range && !reset) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteenable[b]) mem[beat_idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    // Control FSM, burst counters and the issue -> RAM read pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt_addr   <= '0;
            beats_left <= '0;
            iss_v      <= 1'b0;
            iss_addr   <= '0;
            ram_v      <= 1'b0;
            ram_q      <= '0;
        end else if (clken) begin
            iss_v <= rd_issue;
            if (rd_issue) iss_addr <= beat_addr;
            ram_v <= iss_v;
            // The RAM is read one edge after issue, so a same-edge write leaves old data here.
            if (iss_v) ram_q <= iss_in_range ? mem[iss_idx] : '0;
            case (state)
                IDLE: begin
                    if (cmd_accept && n_beats != BURST_WIDTH'(1)) begin
                        state      <= write ? WR_BURST : RD_BURST;
                        cnt_addr   <= address + 1'b1;
                        beats_left <= n_beats - 1'b1;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (rd_issue || wr_beat) begin
                        cnt_addr   <= cnt_addr + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BURST_WIDTH'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_out_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    readdata      <= '0;
                    readdatavalid <= 1'b0;
                end else if (clken) begin
                    readdata      <= ram_q;
                    readdatavalid <= ram_v;
                end
            end
        end else begin : g_out_direct
            assign readdata      = ram_q;
            assign readdatavalid = ram_v;
        end
    endgenerate

endmodule

// File: tb/tb_lab2_qs_onchip_memory_burst.sv
// Bench for the burst RAM slave: one instance per read latency share stimulus,
// read beats are time-stamped and compared against a word-array reference model.
module tb_lab2_qs_onchip_memory_burst;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 40;
    localparam int BW    = 4;
    localparam int AMASK = 63;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect, read, write, clken;
    logic [DW-1:0] writedata;
    logic [BW-1:0] burstcount;
    logic          wr1, rdv1, wr2, rdv2;
    logic [DW-1:0] rd1, rd2;
    logic [1:0]    st1, st2;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    logic last_en = 1'b0;
    int last_acc, last_wait_hi;

    logic [DW-1:0] model [0:63];
    logic [DW-1:0] wq[$];
    logic [63:0]   exp1_q[$], exp2_q[$], obs1_q[$], obs2_q[$];

    lab2_qs_onchip_memory_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .BURST_WIDTH(BW), .READ_LATENCY(1), .INIT_FILE("")) u_lat1 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .burstcount(burstcount), .clken(clken), .waitrequest(wr1), .readdata(rd1),
        .readdatavalid(rdv1), .dbg_state(st1));

    lab2_qs_onchip_memory_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .BURST_WIDTH(BW), .READ_LATENCY(2), .INIT_FILE("")) u_lat2 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .burstcount(burstcount), .clken(clken), .waitrequest(wr2), .readdata(rd2),
        .readdatavalid(rdv2), .dbg_state(st2));

    // Clock / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        last_en <= clken;
    end

    // Beat monitor: records {cycle, data} of every beat presented after an enabled edge
    always @(negedge clk) begin
        if (last_en === 1'b1 && rdv1 === 1'b1) obs1_q.push_back({cyc[31:0], rd1});
        if (last_en === 1'b1 && rdv2 === 1'b1) obs2_q.push_back({cyc[31:0], rd2});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] model_rd(input int a);
        return (a < DEPTH) ? model[a] : '0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp1_q.delete(); exp2_q.delete(); obs1_q.delete(); obs2_q.delete();
    endtask

    task automatic wait_ready(input string what);
        int k;
        k = 0;
        while (wr1 !== 1'b0 && k < 100) begin
            cycle();
            k++;
        end
        vectors++;
        if (k >= 100) begin
            fails++;
            $display("FAIL %s: waitrequest stuck at %b, want 0", what, wr1);
        end
    endtask

    // Driver: read burst; expected beats come from the model at issue time
    task automatic issue_read(input int addr, input int bc);
        int nb;
        wait_ready("read_accept");
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        address = AW'(addr); burstcount = BW'(bc);
        cycle();
        last_acc = cyc;
        chipselect = 1'b0; read = 1'b0;
        nb = (bc == 0) ? 1 : bc;
        for (int i = 0; i < nb; i++) begin
            exp1_q.push_back({32'(last_acc + 1 + i), model_rd((addr + i) & AMASK)});
            exp2_q.push_back({32'(last_acc + 2 + i), model_rd((addr + i) & AMASK)});
        end
        last_wait_hi = 0;
        while (wr1 === 1'b1 && last_wait_hi < 100) begin
            last_wait_hi++;
            cycle();
        end
    endtask

    // Driver: write burst using wq as beat data, optional gap and read noise
    task automatic write_burst(input int addr, input int bc, input logic [3:0] be,
                               input int gap_at, input int gap_len, input bit noise);
        int nb, a;
        logic [DW-1:0] w;
        nb = (bc == 0) ? 1 : bc;
        wait_ready("write_accept");
        chipselect = 1'b1; write = 1'b1; read = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        address = AW'(addr); burstcount = BW'(bc); byteenable = be; writedata = wq[0];
        cycle();
        for (int i = 1; i < nb; i++) begin
            read = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == gap_at && gap_len > 0) begin
                write = 1'b0;
                writedata = $urandom;
                repeat (gap_len) cycle();
                write = 1'b1;
            end
            writedata = wq[i];
            cycle();
        end
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        for (int i = 0; i < nb; i++) begin
            a = (addr + i) & AMASK;
            w = wq[i];
            if (a < DEPTH)
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[a][8*b +: 8] = w[8*b +: 8];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0; burstcount = '0;
        repeat (3) cycle();
        vectors++;
        if (rdv1 !== 1'b0 || rd1 !== '0) begin
            fails++; $display("FAIL reset lat1 out: got v=%b d=%h, want v=0 d=0", rdv1, rd1);
        end
        vectors++;
        if (rdv2 !== 1'b0 || rd2 !== '0) begin
            fails++; $display("FAIL reset lat2 out: got v=%b d=%h, want v=0 d=0", rdv2, rd2);
        end
        vectors++;
        if (wr1 !== 1'b0 || wr2 !== 1'b0 || st1 !== 2'd0 || st2 !== 2'd0) begin
            fails++; $display("FAIL reset idle: got wr=%b%b st=%0d/%0d, want wr=00 st=0", wr1, wr2, st1, st2);
        end
        clken = 1'b0;
        #1;
        vectors++;
        if (wr1 !== 1'b1 || wr2 !== 1'b1) begin
            fails++; $display("FAIL reset clken_wait: got %b%b, want 11", wr1, wr2);
        end
        clken = 1'b1; reset = 1'b0;
        cycle();
    endtask

    task automatic test_fill();
        clear_sb();
        for (int a = 0; a < DEPTH; a += 8) begin
            wq.delete();
            for (int i = 0; i < 8; i++) wq.push_back($urandom);
            write_burst(a, 8, 4'hF, 0, 0, 1'b0);
        end
        for (int a = 0; a < DEPTH; a += 8) issue_read(a, 8);
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != exp1_q.size()) begin fails++; $display("FAIL fill lat1 beats: got %0d, want %0d", obs1_q.size(), exp1_q.size()); end
        vectors++;
        if (obs2_q.size() != exp2_q.size()) begin fails++; $display("FAIL fill lat2 beats: got %0d, want %0d", obs2_q.size(), exp2_q.size()); end
        foreach (exp1_q[i]) if (i < obs1_q.size()) begin
            vectors++;
            if (obs1_q[i] !== exp1_q[i]) begin fails++; $display("FAIL fill lat1 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs1_q[i][63:32], obs1_q[i][31:0], exp1_q[i][63:32], exp1_q[i][31:0]); end
        end
        foreach (exp2_q[i]) if (i < obs2_q.size()) begin
            vectors++;
            if (obs2_q[i] !== exp2_q[i]) begin fails++; $display("FAIL fill lat2 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs2_q[i][63:32], obs2_q[i][31:0], exp2_q[i][63:32], exp2_q[i][31:0]); end
        end
    endtask

    task automatic test_single();
        clear_sb();
        wq = '{32'hDEADBEEF};
        write_burst(5, 1, 4'hF, 0, 0, 1'b0);
        issue_read(5, 1);
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != 1 || obs2_q.size() != 1) begin fails++; $display("FAIL single beats: got %0d/%0d, want 1/1", obs1_q.size(), obs2_q.size()); end
        if (obs1_q.size() > 0) begin
            vectors++;
            if (obs1_q[0] !== {32'(last_acc + 1), 32'hDEADBEEF}) begin fails++; $display("FAIL single lat1: got cyc %0d data %h, want cyc %0d data deadbeef", obs1_q[0][63:32], obs1_q[0][31:0], last_acc + 1); end
        end
        if (obs2_q.size() > 0) begin
            vectors++;
            if (obs2_q[0] !== {32'(last_acc + 2), 32'hDEADBEEF}) begin fails++; $display("FAIL single lat2: got cyc %0d data %h, want cyc %0d data deadbeef", obs2_q[0][63:32], obs2_q[0][31:0], last_acc + 2); end
        end
    endtask

    task automatic test_burst_gap();
        clear_sb();
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        write_burst(16, 4, 4'hF, 2, 2, 1'b0);
        issue_read(16, 4);
        vectors++;
        if (last_wait_hi != 3) begin fails++; $display("FAIL gap waitrequest_cycles: got %0d, want 3", last_wait_hi); end
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != 4 || obs2_q.size() != 4) begin fails++; $display("FAIL gap beats: got %0d/%0d, want 4/4", obs1_q.size(), obs2_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < obs1_q.size()) begin
                vectors++;
                if (obs1_q[i] !== {32'(last_acc + 1 + i), 32'(i + 1)}) begin fails++; $display("FAIL gap lat1 beat %0d: got cyc %0d data %h, want cyc %0d data %0d", i, obs1_q[i][63:32], obs1_q[i][31:0], last_acc + 1 + i, i + 1); end
            end
            if (i < obs2_q.size()) begin
                vectors++;
                if (obs2_q[i] !== {32'(last_acc + 2 + i), 32'(i + 1)}) begin fails++; $display("FAIL gap lat2 beat %0d: got cyc %0d data %h, want cyc %0d data %0d", i, obs2_q[i][63:32], obs2_q[i][31:0], last_acc + 2 + i, i + 1); end
            end
        end
    endtask

    task automatic test_byteenable();
        clear_sb();
        wq = '{32'hFFFFFFFF};
        write_burst(7, 1, 4'hF, 0, 0, 1'b0);
        wq = '{32'h00000000};
        write_burst(7, 1, 4'h5, 0, 0, 1'b0);
        issue_read(7, 1);
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != 1 || obs1_q[0][31:0] !== 32'hFF00FF00) begin fails++; $display("FAIL byteen lat1: got n=%0d data %h, want n=1 data ff00ff00", obs1_q.size(), obs1_q.size() > 0 ? obs1_q[0][31:0] : 32'h0); end
        vectors++;
        if (obs2_q.size() != 1 || obs2_q[0][31:0] !== 32'hFF00FF00) begin fails++; $display("FAIL byteen lat2: got n=%0d data %h, want n=1 data ff00ff00", obs2_q.size(), obs2_q.size() > 0 ? obs2_q[0][31:0] : 32'h0); end
    endtask

    task automatic test_out_of_range();
        clear_sb();
        issue_read(DEPTH - 2, 4);
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back($urandom);
        write_burst(DEPTH - 2, 4, 4'hF, 0, 0, 1'b0);
        issue_read(DEPTH - 4, 4);
        issue_read(DEPTH - 2, 4);
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back($urandom);
        write_burst(62, 4, 4'hF, 0, 0, 1'b0);
        issue_read(62, 4);
        issue_read(0, 3);
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != exp1_q.size()) begin fails++; $display("FAIL oor lat1 beats: got %0d, want %0d", obs1_q.size(), exp1_q.size()); end
        vectors++;
        if (obs2_q.size() != exp2_q.size()) begin fails++; $display("FAIL oor lat2 beats: got %0d, want %0d", obs2_q.size(), exp2_q.size()); end
        foreach (exp1_q[i]) if (i < obs1_q.size()) begin
            vectors++;
            if (obs1_q[i] !== exp1_q[i]) begin fails++; $display("FAIL oor lat1 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs1_q[i][63:32], obs1_q[i][31:0], exp1_q[i][63:32], exp1_q[i][31:0]); end
        end
        foreach (exp2_q[i]) if (i < obs2_q.size()) begin
            vectors++;
            if (obs2_q[i] !== exp2_q[i]) begin fails++; $display("FAIL oor lat2 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs2_q[i][63:32], obs2_q[i][31:0], exp2_q[i][63:32], exp2_q[i][31:0]); end
        end
    endtask

    task automatic test_clken();
        int t, tt;
        clear_sb();
        wait_ready("clken_accept");
        chipselect = 1'b1; read = 1'b1; address = AW'(8); burstcount = BW'(8);
        cycle();
        t = cyc;
        chipselect = 1'b0; read = 1'b0;
        // Edges t+2..t+4 are frozen, so every beat due on or after t+2 slips by 3
        for (int i = 0; i < 8; i++) begin
            tt = t + 1 + i;
            if (tt >= t + 2) tt += 3;
            exp1_q.push_back({32'(tt), model_rd(8 + i)});
            exp2_q.push_back({32'(t + 2 + i + 3), model_rd(8 + i)});
        end
        cycle();
        clken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            vectors++;
            if (wr1 !== 1'b1 || wr2 !== 1'b1) begin fails++; $display("FAIL clken wait %0d: got %b%b, want 11", k, wr1, wr2); end
            vectors++;
            if (rdv1 !== 1'b1 || rd1 !== model_rd(8)) begin fails++; $display("FAIL clken hold1 %0d: got v=%b d=%h, want v=1 d=%h", k, rdv1, rd1, model_rd(8)); end
            vectors++;
            if (rdv2 !== 1'b0) begin fails++; $display("FAIL clken hold2 %0d: got v=%b, want 0", k, rdv2); end
        end
        clken = 1'b1;
        repeat (14) cycle();
        vectors++;
        if (obs1_q.size() != 8 || obs2_q.size() != 8) begin fails++; $display("FAIL clken beats: got %0d/%0d, want 8/8", obs1_q.size(), obs2_q.size()); end
        foreach (exp1_q[i]) if (i < obs1_q.size()) begin
            vectors++;
            if (obs1_q[i] !== exp1_q[i]) begin fails++; $display("FAIL clken lat1 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs1_q[i][63:32], obs1_q[i][31:0], exp1_q[i][63:32], exp1_q[i][31:0]); end
        end
        foreach (exp2_q[i]) if (i < obs2_q.size()) begin
            vectors++;
            if (obs2_q[i] !== exp2_q[i]) begin fails++; $display("FAIL clken lat2 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs2_q[i][63:32], obs2_q[i][31:0], exp2_q[i][63:32], exp2_q[i][31:0]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        clear_sb();
        wait_ready("rstmid_accept");
        chipselect = 1'b1; read = 1'b1; address = AW'(0); burstcount = BW'(8);
        cycle();
        t = cyc;
        chipselect = 1'b0; read = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        vectors++;
        if (rdv1 !== 1'b0 || rd1 !== '0 || rdv2 !== 1'b0 || rd2 !== '0) begin fails++; $display("FAIL rstmid out: got v=%b%b d=%h/%h, want v=00 d=0", rdv1, rdv2, rd1, rd2); end
        vectors++;
        if (st1 !== 2'd0 || wr1 !== 1'b0) begin fails++; $display("FAIL rstmid idle: got st=%0d wr=%b, want st=0 wr=0", st1, wr1); end
        clear_sb();
        reset = 1'b0;
        issue_read(9, 1);
        vectors++;
        if (last_acc != t + 3) begin fails++; $display("FAIL rstmid accept: got cyc %0d, want %0d", last_acc, t + 3); end
        repeat (10) cycle();
        vectors++;
        if (obs1_q.size() != 1 || obs2_q.size() != 1) begin fails++; $display("FAIL rstmid beats: got %0d/%0d, want 1/1", obs1_q.size(), obs2_q.size()); end
        if (obs1_q.size() > 0) begin
            vectors++;
            if (obs1_q[0] !== exp1_q[0]) begin fails++; $display("FAIL rstmid lat1: got cyc %0d data %h, want cyc %0d data %h", obs1_q[0][63:32], obs1_q[0][31:0], exp1_q[0][63:32], exp1_q[0][31:0]); end
        end
        if (obs2_q.size() > 0) begin
            vectors++;
            if (obs2_q[0] !== exp2_q[0]) begin fails++; $display("FAIL rstmid lat2: got cyc %0d data %h, want cyc %0d data %h", obs2_q[0][63:32], obs2_q[0][31:0], exp2_q[0][63:32], exp2_q[0][31:0]); end
        end
    endtask

    task automatic test_read_write_both();
        clear_sb();
        wait_ready("rw_accept");
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = AW'(3);
        writedata = 32'h55; byteenable = 4'hF; burstcount = BW'(1);
        cycle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        model[3] = 32'h55;
        repeat (5) cycle();
        vectors++;
        if (obs1_q.size() != 0 || obs2_q.size() != 0) begin fails++; $display("FAIL rw no_read: got %0d/%0d beats, want 0/0", obs1_q.size(), obs2_q.size()); end
        issue_read(3, 1);
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != 1 || obs1_q[0][31:0] !== 32'h55) begin fails++; $display("FAIL rw readback lat1: got n=%0d data %h, want n=1 data 55", obs1_q.size(), obs1_q.size() > 0 ? obs1_q[0][31:0] : 32'h0); end
        vectors++;
        if (obs2_q.size() != 1 || obs2_q[0][31:0] !== 32'h55) begin fails++; $display("FAIL rw readback lat2: got n=%0d data %h, want n=1 data 55", obs2_q.size(), obs2_q.size() > 0 ? obs2_q[0][31:0] : 32'h0); end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        issue_read(4, 4);
        issue_read(30, 3);
        issue_read(12, 0);
        issue_read(20, 2);
        // Write lands on the same edge the last read beat samples the RAM
        wq = '{32'hA5A5_0F0F ^ 32'($urandom)};
        write_burst(21, 1, 4'hF, 0, 0, 1'b0);
        issue_read(21, 1);
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != exp1_q.size()) begin fails++; $display("FAIL b2b lat1 beats: got %0d, want %0d", obs1_q.size(), exp1_q.size()); end
        vectors++;
        if (obs2_q.size() != exp2_q.size()) begin fails++; $display("FAIL b2b lat2 beats: got %0d, want %0d", obs2_q.size(), exp2_q.size()); end
        foreach (exp1_q[i]) if (i < obs1_q.size()) begin
            vectors++;
            if (obs1_q[i] !== exp1_q[i]) begin fails++; $display("FAIL b2b lat1 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs1_q[i][63:32], obs1_q[i][31:0], exp1_q[i][63:32], exp1_q[i][31:0]); end
        end
        foreach (exp2_q[i]) if (i < obs2_q.size()) begin
            vectors++;
            if (obs2_q[i] !== exp2_q[i]) begin fails++; $display("FAIL b2b lat2 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs2_q[i][63:32], obs2_q[i][31:0], exp2_q[i][63:32], exp2_q[i][31:0]); end
        end
    endtask

    task automatic test_random();
        int addr, bc;
        clear_sb();
        for (int n = 0; n < 40; n++) begin
            addr = $urandom_range(0, 63);
            bc   = $urandom_range(0, 8);
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                for (int i = 0; i < 8; i++) wq.push_back($urandom);
                write_burst(addr, bc, 4'($urandom_range(0, 15)), $urandom_range(1, 7),
                            $urandom_range(0, 2), 1'b1);
            end else begin
                issue_read(addr, bc);
            end
        end
        repeat (6) cycle();
        vectors++;
        if (obs1_q.size() != exp1_q.size()) begin fails++; $display("FAIL random lat1 beats: got %0d, want %0d", obs1_q.size(), exp1_q.size()); end
        vectors++;
        if (obs2_q.size() != exp2_q.size()) begin fails++; $display("FAIL random lat2 beats: got %0d, want %0d", obs2_q.size(), exp2_q.size()); end
        foreach (exp1_q[i]) if (i < obs1_q.size()) begin
            vectors++;
            if (obs1_q[i] !== exp1_q[i]) begin fails++; $display("FAIL random lat1 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs1_q[i][63:32], obs1_q[i][31:0], exp1_q[i][63:32], exp1_q[i][31:0]); end
        end
        foreach (exp2_q[i]) if (i < obs2_q.size()) begin
            vectors++;
            if (obs2_q[i] !== exp2_q[i]) begin fails++; $display("FAIL random lat2 beat %0d: got cyc %0d data %h, want cyc %0d data %h", i, obs2_q[i][63:32], obs2_q[i][31:0], exp2_q[i][63:32], exp2_q[i][31:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_burst_gap();
        test_byteenable();
        test_out_of_range();
        test_clken();
        test_reset_mid_burst();
        test_read_write_both();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
